// File: rtl/ddr_pkg.sv
// rtl/ddr_pkg.sv - shared DDR bank-tracking types and default timing constants
package ddr_pkg;

    typedef enum logic [1:0] {
        BANK_CLOSED  = 2'd0,
        BANK_OPENING = 2'd1,
        BANK_OPEN    = 2'd2,
        BANK_CLOSING = 2'd3
    } bank_state_e;

    typedef enum logic [1:0] {
        CMD_ACT = 2'd0,
        CMD_PRE = 2'd1,
        CMD_RD  = 2'd2,
        CMD_WR  = 2'd3
    } cmd_type_e;

    typedef enum logic [2:0] {
        ERR_NONE         = 3'd0,
        ERR_ACT_OPEN     = 3'd1,
        ERR_RW_CLOSED    = 3'd2,
        ERR_RW_OPENING   = 3'd3,
        ERR_PRE_RECOVERY = 3'd4,
        ERR_ACT_CLOSING  = 3'd5
    } err_code_e;

    localparam int DEF_NUMBER_BANK = 16;
    localparam int DEF_RA_WIDTH    = 15;
    localparam int DEF_T_RCD       = 11;
    localparam int DEF_T_RP        = 11;
    localparam int DEF_T_RTP       = 6;
    localparam int DEF_T_WR_TOT    = 24;
    localparam int CNT_W           = 8;

endpackage

// File: rtl/ddr_bank_fsm.sv
// rtl/ddr_bank_fsm.sv - one bank: row state machine, tRCD/tRP timer, recovery counter
// DDR_RESP_TIMING_CHK_EN adds OPENING/CLOSING and the recovery counter.
module ddr_bank_fsm
    import ddr_pkg::*;
#(
    parameter int RA_WIDTH = DEF_RA_WIDTH,
    parameter int T_RCD    = DEF_T_RCD,
    parameter int T_RP     = DEF_T_RP,
    parameter int T_RTP    = DEF_T_RTP,
    parameter int T_WR_TOT = DEF_T_WR_TOT
) (
    input  logic                clock_t,
    input  logic                reset_n,
    input  logic                act,
    input  logic                pre,
    input  logic                rd,
    input  logic                wr,
    input  logic [RA_WIDTH-1:0] row_in,
    output logic                is_open,
    output logic [RA_WIDTH-1:0] open_row,
    output err_code_e           err
);

    if (T_RCD < 2 || T_RP < 2 || T_RTP < 1 || T_WR_TOT < 1 ||
        T_RCD > 255 || T_RP > 255 || T_RTP > 255 || T_WR_TOT > 255) begin : g_bad_timing
        $error("ddr_bank_fsm: timing parameter outside 8-bit counter range");
    end

    bank_state_e         state_q, state_d;
    logic [RA_WIDTH-1:0] row_q, row_d;
    logic                timer_done;
    logic                rec_busy;

`ifdef DDR_RESP_TIMING_CHK_EN
    localparam bank_state_e ACT_TARGET = BANK_OPENING;
    localparam bank_state_e PRE_TARGET = BANK_CLOSING;
    localparam logic [CNT_W-1:0] RCD_END  = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] RP_END   = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] RTP_LOAD = CNT_W'(T_RTP);
    localparam logic [CNT_W-1:0] WR_LOAD  = CNT_W'(T_WR_TOT);

    logic [CNT_W-1:0] cnt_q, cnt_d, rec_q, rec_d, rec_dec, rec_load;

    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            rec_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            rec_q <= rec_d;
        end
    end

    // Recovery is judged on the value after this cycle's decrement, so a PRE
    // exactly T_RTP / T_WR_TOT cycles after the RD/WR is the first legal one.
    always_comb begin
        cnt_d = cnt_q;
        if (act || (pre && state_q == BANK_OPEN))
            cnt_d = '0;
        else if (state_q == BANK_OPENING || state_q == BANK_CLOSING)
            cnt_d = cnt_q + CNT_W'(1);
        rec_dec  = (rec_q == '0) ? '0 : rec_q - CNT_W'(1);
        rec_load = wr ? WR_LOAD : RTP_LOAD;
        rec_d    = rec_dec;
        if ((rd || wr) && state_q != BANK_CLOSED && rec_load > rec_dec)
            rec_d = rec_load;
    end

    assign timer_done = (cnt_q + CNT_W'(1)) ==
                        ((state_q == BANK_OPENING) ? RCD_END : RP_END);
    assign rec_busy   = (rec_dec != '0);
`else
    localparam bank_state_e ACT_TARGET = BANK_OPEN;
    localparam bank_state_e PRE_TARGET = BANK_CLOSED;

    assign timer_done = 1'b0;
    assign rec_busy   = 1'b0;
`endif

    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BANK_CLOSED;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
        end
    end

    // An illegal ACT still takes effect: it restarts the bank on the new row.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        if (act) begin
            state_d = ACT_TARGET;
            row_d   = row_in;
        end else begin
            case (state_q)
                BANK_OPENING: if (timer_done) state_d = BANK_OPEN;
                BANK_OPEN:    if (pre)        state_d = PRE_TARGET;
                BANK_CLOSING: if (timer_done) state_d = BANK_CLOSED;
                default:      state_d = state_q;
            endcase
        end
    end

    always_comb begin
        err = ERR_NONE;
        if (act) begin
            case (state_q)
                BANK_OPENING, BANK_OPEN: err = ERR_ACT_OPEN;
                BANK_CLOSING:            err = ERR_ACT_CLOSING;
                default:                 err = ERR_NONE;
            endcase
        end else if (rd || wr) begin
            case (state_q)
                BANK_CLOSED, BANK_CLOSING: err = ERR_RW_CLOSED;
                BANK_OPENING:              err = ERR_RW_OPENING;
                default:                   err = ERR_NONE;
            endcase
        end else if (pre && state_q == BANK_OPEN && rec_busy) begin
            err = ERR_PRE_RECOVERY;
        end
    end

    assign is_open  = (state_q == BANK_OPEN);
    assign open_row = row_q;

endmodule

// File: rtl/ddr_bank_responder.sv
// rtl/ddr_bank_responder.sv - DDR command decode, per-bank tracking, error report, row query
// DDR_RESP_TIMING_CHK_EN enables tRCD/tRP/recovery checking in every bank.
module ddr_bank_responder
    import ddr_pkg::*;
#(
    parameter int NUMBER_BANK = DEF_NUMBER_BANK,
    parameter int RA_WIDTH    = DEF_RA_WIDTH,
    parameter int T_RCD       = DEF_T_RCD,
    parameter int T_RP        = DEF_T_RP,
    parameter int T_RTP       = DEF_T_RTP,
    parameter int T_WR_TOT    = DEF_T_WR_TOT
) (
    input  logic                   clock_t,
    input  logic                   reset_n,
    input  logic                   cs_n,
    input  logic                   act_n,
    input  logic                   ras_n,
    input  logic                   cas_n,
    input  logic                   we_n,
    input  logic [1:0]             bg,
    input  logic [1:0]             ba,
    input  logic [13:0]            addr,
    output logic [NUMBER_BANK-1:0] bank_open,
    input  logic [3:0]             q_bank,
    output logic [RA_WIDTH-1:0]    q_row,
    output logic                   cmd_valid,
    output logic [1:0]             cmd_type,
    output logic                   err_valid,
    output logic [2:0]             err_code,
    output logic [3:0]             err_bank
);

    logic                cmd_hit, prea;
    cmd_type_e           cmd_kind;
    logic [3:0]          bank_idx;
    logic [RA_WIDTH-1:0] act_row;
    err_code_e           bank_err [NUMBER_BANK];
    logic [RA_WIDTH-1:0] bank_row [NUMBER_BANK];

    logic                cmd_valid_q, cmd_valid_d, err_valid_q, err_valid_d;
    cmd_type_e           cmd_type_q, cmd_type_d;
    err_code_e           err_code_q, err_code_d;
    logic [3:0]          err_bank_q, err_bank_d;
    logic [RA_WIDTH-1:0] q_row_q, q_row_d;

    always_comb begin
        bank_idx = {bg, ba};
        act_row  = RA_WIDTH'({we_n, addr});
        cmd_hit  = 1'b0;
        cmd_kind = CMD_ACT;
        if (!cs_n) begin
            if (!act_n) begin
                cmd_hit = 1'b1;
            end else begin
                case ({ras_n, cas_n, we_n})
                    3'b010: begin cmd_hit = 1'b1; cmd_kind = CMD_PRE; end
                    3'b101: begin cmd_hit = 1'b1; cmd_kind = CMD_RD;  end
                    3'b100: begin cmd_hit = 1'b1; cmd_kind = CMD_WR;  end
                    default: cmd_hit = 1'b0;
                endcase
            end
        end
        prea = cmd_hit && (cmd_kind == CMD_PRE) && addr[10];
    end

    for (genvar i = 0; i < NUMBER_BANK; i++) begin : g_bank
        logic hit;
        assign hit = cmd_hit && (prea || bank_idx == 4'(i));

        ddr_bank_fsm #(
            .RA_WIDTH (RA_WIDTH),
            .T_RCD    (T_RCD),
            .T_RP     (T_RP),
            .T_RTP    (T_RTP),
            .T_WR_TOT (T_WR_TOT)
        ) u_fsm (
            .clock_t  (clock_t),
            .reset_n  (reset_n),
            .act      (hit && cmd_kind == CMD_ACT),
            .pre      (hit && cmd_kind == CMD_PRE),
            .rd       (hit && cmd_kind == CMD_RD),
            .wr       (hit && cmd_kind == CMD_WR),
            .row_in   (act_row),
            .is_open  (bank_open[i]),
            .open_row (bank_row[i]),
            .err      (bank_err[i])
        );
    end

    // Descending scan leaves the lowest violating bank in err_bank for PREA.
    always_comb begin
        cmd_valid_d = cmd_hit;
        cmd_type_d  = cmd_hit ? cmd_kind : CMD_ACT;
        err_code_d  = ERR_NONE;
        err_bank_d  = '0;
        for (int i = NUMBER_BANK - 1; i >= 0; i--) begin
            if (bank_err[i] != ERR_NONE) begin
                err_code_d = bank_err[i];
                err_bank_d = 4'(i);
            end
        end
        err_valid_d = (err_code_d != ERR_NONE);
        q_row_d     = bank_open[q_bank] ? bank_row[q_bank] : '1;
    end

    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            cmd_valid_q <= 1'b0;
            cmd_type_q  <= CMD_ACT;
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            err_bank_q  <= '0;
            q_row_q     <= '1;
        end else begin
            cmd_valid_q <= cmd_valid_d;
            cmd_type_q  <= cmd_type_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
            err_bank_q  <= err_bank_d;
            q_row_q     <= q_row_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_type  = cmd_type_q;
    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;
    assign err_bank  = err_bank_q;
    assign q_row     = q_row_q;

endmodule
